fifo_wr_arbiter: RTL

Round-robin write arbiter that shares one FIFO_LIFO write port between NREQ producers. Each producer requests access, is granted the port for a burst of up to BURST_LEN words, and is back-pressured through the buffer's Full flag. The block sits in front of FIFO_LIFO in the Wr_clk domain and drives its Wr_En_in and Data_in directly.

---
 rtl/fifo_wr_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO_LIFO write port among NREQ producers.
// States: IDLE | arbitrating, no grant ; BURST | port owned by gnt_idx. Optional ARB_COUNT_EN adds Words_cnt.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int SIZE      = 8,
  parameter int BURST_LEN = 4,
  parameter int GNT_W     = 2,
  parameter int CNT_W     = 3
) (
  input  logic                 Wr_clk,
  input  logic                 RST,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ*SIZE-1:0] Data_in,
  input  logic                 Full_in,
  output logic [NREQ-1:0]      Ack,
  output logic [NREQ-1:0]      Gnt,
  output logic                 Busy,
  output logic                 Wr_En_out,
  output logic [SIZE-1:0]      Data_out
`ifdef ARB_COUNT_EN
  ,
  output logic [15:0]          Words_cnt
`endif
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_nxt;
  logic [GNT_W-1:0]  gnt_idx, last_idx, pick_idx;
  logic [CNT_W-1:0]  burst_cnt;
  logic [NREQ-1:0]   gnt_oh;
  logic              pick_found, req_gnt, accept, burst_last;

  // Search starts just after the last winner so it gets lowest priority.
  always_comb begin : arb_pick
    logic [GNT_W-1:0] cand;
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GNT_W'((int'(last_idx) + k) % NREQ);
      if (!pick_found && Req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_oh   = '0;
    Data_out = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_oh[i] = (gnt_idx == GNT_W'(i));
      if (gnt_idx == GNT_W'(i)) Data_out = Data_in[i*SIZE +: SIZE];
    end
  end

  assign req_gnt    = |(Req & gnt_oh);
  assign accept     = (state == BURST) && req_gnt && !Full_in && !RST;
  assign burst_last = (burst_cnt == CNT_W'(BURST_LEN - 1));

  always_comb begin
    state_nxt = state;
    Wr_En_out = accept;
    Ack       = accept ? gnt_oh : '0;
    Gnt       = (state == BURST) ? gnt_oh : '0;
    Busy      = (state == BURST);
    case (state)
      IDLE:  if (pick_found) state_nxt = BURST;
      BURST: begin
        if (accept && burst_last) state_nxt = IDLE;
        else if (!req_gnt)        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Wr_clk) begin
    if (RST) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      last_idx  <= GNT_W'(NREQ - 1);
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_found) begin
        gnt_idx   <= pick_idx;
        last_idx  <= pick_idx;
        burst_cnt <= '0;
      end else if (accept) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

`ifdef ARB_COUNT_EN
  always_ff @(posedge Wr_clk) begin
    if (RST)                                     Words_cnt <= '0;
    else if (Wr_En_out && Words_cnt != 16'hFFFF) Words_cnt <= Words_cnt + 16'd1;
  end
`endif

endmodule
